// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture path.
package pwm_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_MEASURE,
        CAP_STALLED
    } capture_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Pin synchroniser with one extra delay flop; emits the synchronised level and a rise strobe.
module pwm_edge_sync
    import pwm_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clock cycles, one update per period,
// with stuck-line detection when no rising edge arrives within the counter range.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             pwm_in_i,
    output logic             period_start_o,
    output logic             measure_valid_o,
    output logic [WIDTH-1:0] measured_period_o,
    output logic [WIDTH-1:0] measured_duty_o,
    output logic             timeout_o,
    output logic             level_o
);

    localparam logic [WIDTH-1:0] CntMax = '1;
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic level, rise;

    capture_state_t   state_q;
    logic [WIDTH-1:0] period_cnt_q, high_cnt_q;
    logic [WIDTH-1:0] period_q, duty_q;
    logic             start_q, valid_q, timeout_q;

    pwm_edge_sync u_edge_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (pwm_in_i),
        .level_o (level),
        .rise_o  (rise)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= CAP_IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            // Disable overrides any edge seen this cycle; held results stay visible.
            if (!enable_i) begin
                state_q      <= CAP_IDLE;
                period_cnt_q <= '0;
                high_cnt_q   <= '0;
                timeout_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    CAP_IDLE: begin
                        if (rise) begin
                            state_q      <= CAP_MEASURE;
                            period_cnt_q <= CntOne;
                            high_cnt_q   <= CntOne;
                            start_q      <= 1'b1;
                        end
                    end
                    CAP_MEASURE: begin
                        if (rise) begin
                            period_q     <= period_cnt_q;
                            duty_q       <= high_cnt_q;
                            valid_q      <= 1'b1;
                            start_q      <= 1'b1;
                            period_cnt_q <= CntOne;
                            high_cnt_q   <= CntOne;
                        end else if (period_cnt_q == CntMax) begin
                            state_q   <= CAP_STALLED;
                            timeout_q <= 1'b1;
                        end else begin
                            period_cnt_q <= period_cnt_q + CntOne;
                            high_cnt_q   <= high_cnt_q + WIDTH'(level);
                        end
                    end
                    CAP_STALLED: begin
                        // The partial period is discarded; measuring restarts from this edge.
                        if (rise) begin
                            state_q      <= CAP_MEASURE;
                            period_cnt_q <= CntOne;
                            high_cnt_q   <= CntOne;
                            start_q      <= 1'b1;
                            timeout_q    <= 1'b0;
                        end
                    end
                    default: state_q <= CAP_IDLE;
                endcase
            end
        end
    end

    assign period_start_o    = start_q;
    assign measure_valid_o   = valid_q;
    assign measured_period_o = period_q;
    assign measured_duty_o   = duty_q;
    assign timeout_o         = timeout_q;
    assign level_o           = level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM waveforms cycle by cycle and checks pulses and results.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic       period_start, measure_valid, timeout, level;
    logic [7:0] measured_period, measured_duty;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ps_cnt, mv_cnt, last_ps_cyc;
    int         prev_p, prev_d;
    logic [7:0] last_per, last_duty;
    logic       to_seen, to_at_ps;

    pwm_capture #(.WIDTH(8)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .enable_i          (enable),
        .pwm_in_i          (pwm_in),
        .period_start_o    (period_start),
        .measure_valid_o   (measure_valid),
        .measured_period_o (measured_period),
        .measured_duty_o   (measured_duty),
        .timeout_o         (timeout),
        .level_o           (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and record any pulses seen just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (period_start === 1'b1) begin
            ps_cnt++;
            last_ps_cyc = cyc;
            to_at_ps    = timeout;
        end
        if (measure_valid === 1'b1) begin
            mv_cnt++;
            last_per  = measured_period;
            last_duty = measured_duty;
            check("valid_with_start", {31'd0, period_start}, 1);
        end
        if (timeout === 1'b1) to_seen = 1'b1;
    endtask

    task automatic clr();
        ps_cnt  = 0;
        mv_cnt  = 0;
        to_seen = 1'b0;
    endtask

    task automatic period(input int p, input int d);
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < d);
            tick();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_start"}, {31'd0, period_start}, 0);
        check({tag, "_valid"}, {31'd0, measure_valid}, 0);
        check({tag, "_per"}, {24'd0, measured_period}, 0);
        check({tag, "_duty"}, {24'd0, measured_duty}, 0);
        check({tag, "_timeout"}, {31'd0, timeout}, 0);
        check({tag, "_level"}, {31'd0, level}, 0);
    endtask

    task automatic wait_timeout(input string tag, input logic lvl);
        for (int i = 0; i < 400 && timeout !== 1'b1; i++) tick();
        check({tag, "_up"}, {31'd0, timeout}, 1);
        check({tag, "_delay"}, cyc - last_ps_cyc, 255);
        check({tag, "_level"}, {31'd0, level}, {31'd0, lvl});
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        pwm_in = 1'b1;
        clr();
        last_ps_cyc = 0;
        to_at_ps    = 1'b0;
        repeat (3) tick();
        check_zero_outputs("in_reset");
        pwm_in = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();

        // First rise after reset: start pulse only.
        clr();
        period(20, 7);
        check("first_start", ps_cnt, 1);
        check("first_novalid", mv_cnt, 0);
        check("first_per_zero", {24'd0, measured_period}, 0);

        // Period 63, duty sweep; each rise reports the previous period.
        prev_p = 20;
        prev_d = 7;
        for (int d = 1; d <= 62; d++) begin
            clr();
            period(63, d);
            check("sweep_valid_cnt", mv_cnt, 1);
            check("sweep_per", {24'd0, last_per}, prev_p);
            check("sweep_duty", {24'd0, last_duty}, prev_d);
            prev_p = 63;
            prev_d = d;
        end

        // Stuck low.
        clr();
        pwm_in = 1'b0;
        wait_timeout("stuck_low", 1'b0);
        repeat (20) tick();
        check("stuck_low_novalid", mv_cnt, 0);
        check("stuck_low_hold", {31'd0, timeout}, 1);

        // Rise out of the stall, then stuck high.
        clr();
        pwm_in = 1'b1;
        for (int i = 0; i < 10 && ps_cnt == 0; i++) tick();
        check("unstall_start", ps_cnt, 1);
        check("unstall_to_at_start", {31'd0, to_at_ps}, 0);
        check("unstall_novalid", mv_cnt, 0);
        wait_timeout("stuck_high", 1'b1);
        check("stuck_high_novalid", mv_cnt, 0);

        pwm_in = 1'b0;
        repeat (3) tick();
        clr();
        period(30, 10);
        check("recover_start", ps_cnt, 1);
        check("recover_novalid", mv_cnt, 0);
        check("recover_to_clear", {31'd0, timeout}, 0);
        clr();
        period(30, 10);
        check("recover_valid", mv_cnt, 1);
        check("recover_per", {24'd0, last_per}, 30);
        check("recover_duty", {24'd0, last_duty}, 10);

        // Longest measurable period, then one cycle more.
        clr();
        period(255, 1);
        check("p255a_per", {24'd0, last_per}, 30);
        clr();
        period(255, 1);
        check("p255_valid", mv_cnt, 1);
        check("p255_per", {24'd0, last_per}, 255);
        check("p255_duty", {24'd0, last_duty}, 1);
        check("p255_no_timeout", {31'd0, to_seen}, 0);
        clr();
        period(256, 1);
        check("p256_prev_per", {24'd0, last_per}, 255);
        clr();
        period(20, 5);
        check("p256_stalled", {31'd0, to_seen}, 1);
        check("p256_novalid", mv_cnt, 0);
        check("p256_start", ps_cnt, 1);
        check("p256_to_at_start", {31'd0, to_at_ps}, 0);

        // Disable lands exactly on the cycle the rise is evaluated.
        clr();
        pwm_in = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            pwm_in = ((i / 4) % 2) == 0;
            tick();
        end
        check("dis_nostart", ps_cnt, 0);
        check("dis_novalid", mv_cnt, 0);
        check("dis_per_held", {24'd0, measured_period}, 255);
        check("dis_duty_held", {24'd0, measured_duty}, 1);
        check("dis_timeout", {31'd0, timeout}, 0);
        pwm_in = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        clr();
        period(40, 13);
        check("reen_start", ps_cnt, 1);
        check("reen_novalid", mv_cnt, 0);
        clr();
        period(40, 13);
        check("reen_per", {24'd0, last_per}, 40);
        check("reen_duty", {24'd0, last_duty}, 13);

        // Async reset between edges mid-measurement.
        pwm_in = 1'b1;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        #1;
        reset  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) tick();
        clr();
        period(25, 8);
        check("post_rst_start", ps_cnt, 1);
        check("post_rst_novalid", mv_cnt, 0);
        clr();
        period(25, 8);
        check("post_rst_valid", mv_cnt, 1);
        check("post_rst_per", {24'd0, last_per}, 25);
        check("post_rst_duty", {24'd0, last_duty}, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform, reporting period and high-time in clock cycles once per PWM period. It is the receive-side counterpart to the PWM generator, and the two share the same period/duty semantics. A generator configured for period P and duty D therefore reads back as P/D. It sits at input pins or in loopback benches, and feeds control logic that needs the measured duty cycle.

## Interface
- WIDTH, 8, width of the period/duty counters; maximum measurable period is 2^WIDTH-1 cycles.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- enable  input  1  synchronous; when low, the block sits in IDLE with counters cleared.
- pwm_in  input  1  asynchronous PWM input; synchronised internally.
- period_start  output  1  one-cycle pulse on each detected rising edge of pwm_in while enabled.
- measure_valid  output  1  one-cycle pulse when measured_period and measured_duty are updated.
- measured_period  output  WIDTH  cycles between the last two rising edges; held until next update.
- measured_duty  output  WIDTH  high cycles within that period; held until next update.
- timeout  output  1  high while no rising edge has been seen for 2^WIDTH-1 cycles (stuck line).
- level  output  1  synchronised pwm_in; qualifies timeout (0 = stuck low, 1 = stuck high).

## Operation
- Input path: 2-flop synchroniser s1→s2, then s3 = s2 delayed one cycle. rise = s2 & ~s3.
- States:
  - IDLE: after reset or while enable=0. On rise: go to MEASURE, load counters, pulse period_start. No measure_valid is produced, because the previous period is unknown.
  - MEASURE: on a non-rise cycle, period_cnt++ and high_cnt += s2. On rise: register period_cnt→measured_period and high_cnt→measured_duty, pulse measure_valid and period_start, reload counters.
  - STALLED: entered from MEASURE on a non-rise cycle with period_cnt == 2^WIDTH-1. Counters hold and timeout=1. On rise: go to MEASURE, reload counters, pulse period_start, no measure_valid (partial period discarded), timeout→0.
- Counter reload on rise: period_cnt=1, high_cnt=1. The rise cycle is the first cycle of the new period.
- Width rules: high_cnt ≤ period_cnt always, so no duty overflow. A valid measurement has 1 ≤ duty ≤ period-1. A period of exactly 2^WIDTH-1 is valid; one cycle more stalls.
- enable=0 forces IDLE on the next edge: counters cleared, timeout=0. Held measured_* values are kept. enable=0 coinciding with rise: enable wins, no pulses.
- Reset values: all outputs 0, counters 0, synchroniser flops 0, state IDLE.

## Timing
- pwm_in is first sampled high at posedge k: s2=1 after k+1, rise is evaluated in the k+1..k+2 cycle, and registered outputs assert after posedge k+2.
- Latency is 2 cycles after first sampling; identical for every output, so measurements are unaffected.
- measure_valid and period_start are single-cycle and coincide on every measured edge.
- measured_* change only in the cycle measure_valid rises, and are stable otherwise.
- timeout asserts 2^WIDTH-1 cycles after the last rise, plus the 2-cycle pipeline. It deasserts in the same cycle period_start pulses.
- Reset asserted mid-period, even between clock edges, zeroes outputs combinationally through the async clear. No measurement is emitted after release until two rises are seen.

## Structure
- Shared package pwm_pkg: typedef enum capture_state_t {CAP_IDLE, CAP_MEASURE, CAP_STALLED}; localparam SYNC_STAGES = 2.
- Sub-module pwm_edge_sync: synchroniser, delay flop and rise detect. It outputs level and rise, and is reusable by other pin-facing blocks.
- Top holds the FSM, the two counters and the output registers.

## Test plan
- Reset, then a pwm_in rise: all outputs 0 during reset. The first rise produces period_start=1 and measure_valid=0.
- Loop back the PWM generator with period 63, sweeping duty 1..62, switching mid-period. After a one-period settle, every measure_valid reports 63 and the active duty.
- Duty 0 (stuck low), then stuck high:
  - timeout=1 exactly 255 cycles after the last rise, with level=0 and then level=1.
  - No measure_valid while stalled.
  - The next rise clears timeout with no valid; the following rise gives a correct measurement.
- Period 255, duty 1: measure_valid reports 255/1 with timeout staying 0. Period 256 stalls with no valid.
- enable dropped mid-period, coinciding with a rise: no pulses, measured_* held. Re-enable: first rise has no valid, the second reports correctly.
- Async reset pulse between clock edges mid-measurement: outputs 0 immediately, then recovery as in the first scenario.
